// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode/funct3 constants and writeback FSM state type
package riscv_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {IDLE, MEM_WAIT} mwb_state_t;
endpackage

// File: rtl/load_store_align.sv
// load_store_align: store lane/strobe generation, load extraction/extension, misalignment detection
module load_store_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        store_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        fault_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        bad_f3;
  always_comb begin
    wstrb_o = funct3_i[1:0] == 2'b00 ? 4'b0001 << off_i :
              funct3_i[1:0] == 2'b01 ? 4'b0011 << off_i : 4'b1111;
    wdata_o = funct3_i[1:0] == 2'b00 ? {4{rs2_i[7:0]}} :
              funct3_i[1:0] == 2'b01 ? {2{rs2_i[15:0]}} : rs2_i;
    b = rdata_i[{off_i, 3'b000} +: 8];
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o = funct3_i == F3_B  ? {{24{b[7]}}, b} :
             funct3_i == F3_BU ? {24'b0, b} :
             funct3_i == F3_H  ? {{16{h[15]}}, h} :
             funct3_i == F3_HU ? {16'b0, h} : rdata_i;
    // funct3 encodings 011/11x are holes for loads; stores only define B/H/W
    bad_f3 = store_i ? funct3_i > F3_W : (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11);
    fault_o = bad_f3 || (funct3_i[1:0] == 2'b01 && off_i[0]) ||
              (funct3_i[1:0] == 2'b10 && off_i != 2'b00);
  end
endmodule

// File: rtl/mem_writeback.sv
// mem_writeback: memory/writeback stage driving dmem handshake and register-file write port
module mem_writeback
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int XLEN = 32
) (
  input  logic            req,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] result_in,
  input  logic [XLEN-1:0] rs2_value_in,
  input  logic [4:0]      rd_in,
  output logic            stall_out,
  output logic            dmem_valid,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rd_write,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] rd_value_out,
  output logic            misaligned_out,
  output logic            bus_error_out
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  mwb_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic            dv_q, dv_d, dwe_q, dwe_d;
  logic [XLEN-1:0] daddr_q, daddr_d, dwdata_q, dwdata_d;
  logic [3:0]      dwstrb_q, dwstrb_d;
  logic            rdw_q, rdw_d, mis_q, mis_d, berr_q, berr_d;
  logic [4:0]      rdo_q, rdo_d;
  logic [XLEN-1:0] rdv_q, rdv_d;
  logic            is_alu, is_ld, is_st, waiting, fault;
  logic [3:0]      wstrb;
  logic [31:0]     wdata, ldata;
  assign waiting = state_q == MEM_WAIT;
  assign is_alu = opcode_in inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
  assign is_ld = opcode_in == OPC_LOAD;
  assign is_st = opcode_in == OPC_STORE;
  // One aligner serves both request decode (IDLE) and load return (MEM_WAIT)
  load_store_align u_align (
    .funct3_i (waiting ? f3_q : funct3_in),
    .store_i  (is_st),
    .off_i    (waiting ? off_q : result_in[1:0]),
    .rs2_i    (rs2_value_in),
    .rdata_i  (dmem_rdata),
    .wstrb_o  (wstrb),
    .wdata_o  (wdata),
    .load_o   (ldata),
    .fault_o  (fault)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    f3_d = f3_q;
    off_d = off_q;
    ld_rd_d = ld_rd_q;
    dv_d = dv_q;
    dwe_d = dwe_q;
    daddr_d = daddr_q;
    dwdata_d = dwdata_q;
    dwstrb_d = dwstrb_q;
    rdw_d = 1'b0;
    rdo_d = rdo_q;
    rdv_d = rdv_q;
    mis_d = 1'b0;
    berr_d = 1'b0;
    if (!waiting) begin
      if (ex_valid && is_alu) begin
        rdw_d = |rd_in;
        rdo_d = rd_in;
        rdv_d = result_in;
      end else if (ex_valid && (is_ld || is_st)) begin
        if (fault) mis_d = 1'b1;
        else begin
          state_d = MEM_WAIT;
          dv_d = 1'b1;
          dwe_d = is_st;
          daddr_d = {result_in[XLEN-1:2], 2'b00};
          dwdata_d = wdata;
          dwstrb_d = is_st ? wstrb : 4'b0000;
          f3_d = funct3_in;
          off_d = result_in[1:0];
          ld_rd_d = rd_in;
        end
      end
    end else if (dmem_ready) begin
      state_d = IDLE;
      dv_d = 1'b0;
      cnt_d = '0;
      rdw_d = !dwe_q && |ld_rd_q;
      rdo_d = dwe_q ? rdo_q : ld_rd_q;
      rdv_d = dwe_q ? rdv_q : ldata;
    end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      dv_d = 1'b0;
      cnt_d = '0;
      berr_d = 1'b1;
    end else cnt_d = cnt_q + CW'(1);
  end
  always_ff @(posedge req) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      f3_q <= '0;
      off_q <= '0;
      ld_rd_q <= '0;
      dv_q <= 1'b0;
      dwe_q <= 1'b0;
      daddr_q <= '0;
      dwdata_q <= '0;
      dwstrb_q <= '0;
      rdw_q <= 1'b0;
      rdo_q <= '0;
      rdv_q <= '0;
      mis_q <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      f3_q <= f3_d;
      off_q <= off_d;
      ld_rd_q <= ld_rd_d;
      dv_q <= dv_d;
      dwe_q <= dwe_d;
      daddr_q <= daddr_d;
      dwdata_q <= dwdata_d;
      dwstrb_q <= dwstrb_d;
      rdw_q <= rdw_d;
      rdo_q <= rdo_d;
      rdv_q <= rdv_d;
      mis_q <= mis_d;
      berr_q <= berr_d;
    end
  end
  assign stall_out = waiting;
  assign dmem_valid = dv_q;
  assign dmem_we = dwe_q;
  assign dmem_addr = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign dmem_wstrb = dwstrb_q;
  assign rd_write = rdw_q;
  assign rd_out = rdo_q;
  assign rd_value_out = rdv_q;
  assign misaligned_out = mis_q;
  assign bus_error_out = berr_q;
endmodule
